// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM-stage data-memory controller.
// The MEM_TIMEOUT_EN watchdog uses TIMEOUT_DATA as its substitute read value.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 22;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. While hold is high the payload is frozen and the
// write-enable is cleared, so a stalled op never produces a duplicate writeback.
module mem_wb_reg
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic [DATA_W-1:0] result_d,
  input  logic [4:0]        dst_d,
  input  logic              use_d,
  output logic [DATA_W-1:0] result_q,
  output logic [4:0]        dst_q,
  output logic              use_q
);

  // NOTE: sequential state is written with <= only, so every register samples
  // the pre-edge value of its inputs regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      dst_q    <= '0;
      use_q    <= 1'b0;
    end else if (hold) begin
      use_q    <= 1'b0;
    end else begin
      result_q <= result_d;
      dst_q    <= dst_d;
      use_q    <= use_d;
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage data-memory access controller: req/ack handshake, pipeline stall
// and MEM/WB ownership. Define MEM_TIMEOUT_EN to enable the BUSY watchdog.
module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              MEM_re,
  input  logic              MEM_we,
  input  logic [DATA_W-1:0] MEM_ALU_result,
  input  logic [DATA_W-1:0] MEM_data,
  input  logic              MEM_use_dst_reg,
  input  logic [4:0]        MEM_dst_reg,
  input  logic              MEM_mem_ALU_select,
  output logic              dmem_req,
  output logic              dmem_wr,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              mem_stall,
  output logic              mem_err,
  output logic [DATA_W-1:0] WB_result,
  output logic [4:0]        WB_dst_reg,
  output logic              WB_use_dst_reg
);

  state_t            state;
  logic [DATA_W-1:0] rdata_q;
  logic [4:0]        dst_q;
  logic              use_dst_q;
  logic              flushed_q;
  logic              start;

  logic [DATA_W-1:0] wb_result_d;
  logic [4:0]        wb_dst_d;
  logic              wb_use_d;

  // A flushed op never reaches the bus; a request with both re and we is a store.
  assign start     = (state == IDLE) && (MEM_re || MEM_we) && !flush;
  assign mem_stall = start || (state == BUSY);

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);
  logic [7:0] busy_cnt;
  logic       err_q;
  assign mem_err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign mem_err        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      dmem_req   <= 1'b0;
      dmem_wr    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      rdata_q    <= '0;
      dst_q      <= '0;
      use_dst_q  <= 1'b0;
      flushed_q  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      busy_cnt   <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dmem_req   <= 1'b1;
            dmem_wr    <= MEM_we;
            dmem_addr  <= MEM_ALU_result[ADDR_W-1:0];
            dmem_wdata <= MEM_data;
            dst_q      <= MEM_dst_reg;
            use_dst_q  <= MEM_use_dst_reg;
            flushed_q  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            busy_cnt   <= '0;
`endif
            state      <= BUSY;
          end
        end
        BUSY: begin
          // The bus transaction always runs to completion; flush only kills writeback.
          if (flush) flushed_q <= 1'b1;
          if (dmem_ack) begin
            rdata_q  <= dmem_rdata;
            dmem_req <= 1'b0;
            state    <= DONE;
          end
`ifdef MEM_TIMEOUT_EN
          else if (busy_cnt == TO_LIMIT - 8'd1) begin
            rdata_q  <= DATA_W'(TIMEOUT_DATA);
            dmem_req <= 1'b0;
            err_q    <= 1'b1;
            state    <= DONE;
          end else begin
            busy_cnt <= busy_cnt + 8'd1;
          end
`endif
        end
        DONE: begin
`ifdef MEM_TIMEOUT_EN
          err_q <= 1'b0;
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    wb_result_d = MEM_ALU_result;
    wb_dst_d    = MEM_dst_reg;
    wb_use_d    = MEM_use_dst_reg && !flush;
    if (state == DONE) begin
      if (MEM_mem_ALU_select) wb_result_d = rdata_q;
      wb_dst_d = dst_q;
      wb_use_d = use_dst_q && !dmem_wr && !flushed_q && !flush && !mem_err;
    end
  end

  mem_wb_reg #(
    .DATA_W (DATA_W)
  ) u_mem_wb_reg (
    .clk      (clk),
    .rst      (rst),
    .hold     (mem_stall),
    .result_d (wb_result_d),
    .dst_d    (wb_dst_d),
    .use_d    (wb_use_d),
    .result_q (WB_result),
    .dst_q    (WB_dst_reg),
    .use_q    (WB_use_dst_reg)
  );

endmodule
